captura_mpu: RTL
================

CAPTURA_MPU -- requirements
Module: captura_mpu

Interface
REQ-001 Parameter N_AMOSTRAS, default 30, is the samples per motion window.
REQ-002 Parameter LARGURA, default 32, is the signed sample width in bits.
REQ-003 Parameter LIMIAR, default 500, is the motion trigger threshold on |sample delta|.
REQ-004 Parameter HOLD_CICLOS, default 4, is the number of cycles mov stays high per window.
REQ-005 Parameter TIMEOUT, default 1000, is the maximum idle cycles between samples inside a window.
REQ-006 Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1 bit, is the asynchronous active-high reset.
REQ-008 Port amostra, input, LARGURA bits, is the signed accelerometer sample.
REQ-009 Port amostra_valid, input, 1 bit, marks amostra as valid.
REQ-010 Port amostra_ready, output, 1 bit; a sample is accepted when valid and ready are both high on a rising edge.
REQ-011 Port ldr, input, 5 bits, carries the raw LDR flags.
REQ-012 Port mpu, output, N_AMOSTRAS*LARGURA bits, signed, carries the packed window.
REQ-013 Port ldr_out, output, 5 bits, carries the LDR flags latched with the window.
REQ-014 Port mov, output, 1 bit, is the motion-window-valid flag for the recognizer.

Function
REQ-015 The FSM SHALL have exactly three states: OCIOSO, CAPTURA and ENTREGA.
REQ-016 amostra_ready SHALL be 1 in OCIOSO and CAPTURA and 0 in ENTREGA.
REQ-017 In OCIOSO, each accepted sample SHALL be stored in register anterior and set flag tem_anterior.
REQ-018 Delta SHALL be computed as amostra minus anterior in LARGURA+1 bits, sign-extended, with no overflow or wrap.
REQ-019 In OCIOSO, an accepted sample with tem_anterior=1 and |delta| > LIMIAR (strictly greater) SHALL be stored at index 0, set the count to 1 and enter CAPTURA.
REQ-020 The first sample after reset SHALL never trigger capture, because tem_anterior=0.
REQ-021 In CAPTURA, each accepted sample k (0..N_AMOSTRAS-1) SHALL be written to mpu bits [LARGURA*k+LARGURA-1 : LARGURA*k]; delta SHALL not be evaluated.
REQ-022 Acceptance of sample index N_AMOSTRAS-1 SHALL latch ldr into ldr_out on the same edge and enter ENTREGA.
REQ-023 mov SHALL go high on the cycle after the edge that accepts the last sample.
REQ-024 mov SHALL stay high for exactly HOLD_CICLOS cycles, then the FSM SHALL return to OCIOSO.
REQ-025 On return to OCIOSO, anterior SHALL equal the last captured sample and tem_anterior SHALL be 1.
REQ-026 mpu and ldr_out SHALL stay stable from mov rise until the next window's first sample is accepted.
REQ-027 mpu and ldr_out SHALL never change while mov=1.
REQ-028 In CAPTURA, a gap counter SHALL reset on each accepted sample and increment otherwise.
REQ-029 When the gap counter reaches TIMEOUT, the FSM SHALL abort to OCIOSO with the count at 0 and mov kept 0; partial mpu contents are don't-care.
REQ-030 An abort SHALL clear tem_anterior.
REQ-031 amostra_valid held high in ENTREGA SHALL not be accepted, and no sample SHALL be lost on the ENTREGA-to-OCIOSO edge.
REQ-032 mov SHALL be registered (no combinational path from inputs).
REQ-033 The sample counter SHALL use ceil(log2(N_AMOSTRAS+1)) bits.
REQ-034 The hold counter SHALL saturate-free count 0..HOLD_CICLOS-1.

Reset
REQ-035 On reset, the FSM SHALL go to OCIOSO and all counters SHALL be 0.
REQ-036 On reset, mov, mpu, ldr_out, anterior and tem_anterior SHALL all be 0.
REQ-037 On reset, amostra_ready SHALL be 1 on the first edge after reset deasserts.
REQ-038 Reset asserted mid-CAPTURA or mid-ENTREGA SHALL discard the window immediately and drop mov asynchronously.

Structure
REQ-039 A shared package SHALL hold the FSM state enum and the defaults for N_AMOSTRAS, LARGURA, LIMIAR, HOLD_CICLOS and TIMEOUT, shared with the recognizer.
REQ-040 Sub-module detector_mov SHALL contain the delta, abs and threshold compare, taking anterior, amostra and LIMIAR and producing disparo.

Verification
REQ-041 Samples 0,100,700 then 29 more samples of 5 -> capture starts at 700; mpu[31:0]=700; mov rises one cycle after the 30th capture sample and stays high 4 cycles.
REQ-042 Samples 0 then 500 -> no trigger (equal to LIMIAR); 0 then 501 -> trigger.
REQ-043 Samples -2147483648 then 2147483647 -> |delta|=4294967295, trigger with no wrap.
REQ-044 Capture 10 samples, then valid low 1000 cycles -> abort, mov never rises; next sample does not trigger.
REQ-045 valid held high continuously with ldr=5'b00001 -> ready=0 for exactly 4 cycles, ldr_out=5'b00001, mpu unchanged during mov.
REQ-046 Reset pulse at capture sample 15 -> mov=0, mpu=0, FSM OCIOSO; the next sample is stored without trigger.

Source files
------------

// File: rtl/captura_mpu_pkg.sv
// Shared definitions for the motion-window capture and the recognizer:
// FSM states, default window parameters and a counter-width helper.
package captura_mpu_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CAPTURA = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    localparam int N_AMOSTRAS_PADRAO  = 30;
    localparam int LARGURA_PADRAO     = 32;
    localparam int LIMIAR_PADRAO      = 500;
    localparam int HOLD_CICLOS_PADRAO = 4;
    localparam int TIMEOUT_PADRAO     = 1000;

    // Bits needed for a counter holding the values 0..n-1 (at least one bit).
    function automatic int bits_para(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/detector_mov.sv
// Motion trigger: true when |amostra - anterior| is strictly above LIMIAR.
// The difference is taken one bit wider than the samples so it never wraps.
module detector_mov #(
    parameter int LARGURA = 32,
    parameter int LIMIAR  = 500
) (
    input  logic signed [LARGURA-1:0] anterior,
    input  logic signed [LARGURA-1:0] amostra,
    output logic                      disparo
);

    logic signed [LARGURA:0] delta;
    logic        [LARGURA:0] modulo;

    always_comb begin
        delta   = {amostra[LARGURA-1], amostra} - {anterior[LARGURA-1], anterior};
        // The most negative delta is -(2^LARGURA - 1), so negation always fits.
        modulo  = delta[LARGURA] ? (~delta + 1'b1) : delta;
        disparo = (modulo > (LARGURA+1)'(LIMIAR));
    end

endmodule

// File: rtl/captura_mpu.sv
// Captures a window of N_AMOSTRAS accelerometer samples once motion is seen
// and presents it to the recognizer with a registered HOLD_CICLOS-long mov pulse.
module captura_mpu
    import captura_mpu_pkg::*;
#(
    parameter int N_AMOSTRAS  = N_AMOSTRAS_PADRAO,
    parameter int LARGURA     = LARGURA_PADRAO,
    parameter int LIMIAR      = LIMIAR_PADRAO,
    parameter int HOLD_CICLOS = HOLD_CICLOS_PADRAO,
    parameter int TIMEOUT     = TIMEOUT_PADRAO
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic signed [LARGURA-1:0]            amostra,
    input  logic                                 amostra_valid,
    output logic                                 amostra_ready,
    input  logic [4:0]                           ldr,
    output logic signed [N_AMOSTRAS*LARGURA-1:0] mpu,
    output logic [4:0]                           ldr_out,
    output logic                                 mov
);

    localparam int CW = bits_para(N_AMOSTRAS + 1);
    localparam int GW = bits_para(TIMEOUT);
    localparam int HW = bits_para(HOLD_CICLOS);

    estado_t                   estado, estado_prox;
    logic [CW-1:0]             cnt_amostra;
    logic [GW-1:0]             cnt_gap;
    logic [HW-1:0]             cnt_hold;
    logic signed [LARGURA-1:0] anterior;
    logic                      tem_anterior;
    logic                      aceita;
    logic                      disparo;
    logic                      ultima;

    detector_mov #(
        .LARGURA (LARGURA),
        .LIMIAR  (LIMIAR)
    ) u_detector (
        .anterior (anterior),
        .amostra  (amostra),
        .disparo  (disparo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) estado <= OCIOSO;
        else       estado <= estado_prox;
    end

    always_comb begin
        // NOTE: every output of this block is given a default before the case,
        // so no path leaves a signal unassigned and no latch is inferred.
        estado_prox   = estado;
        amostra_ready = (estado != ENTREGA);
        aceita        = amostra_valid && amostra_ready;
        ultima        = (cnt_amostra == CW'(N_AMOSTRAS - 1));
        unique case (estado)
            OCIOSO: begin
                if (aceita && tem_anterior && disparo) estado_prox = CAPTURA;
            end
            CAPTURA: begin
                if (aceita) begin
                    if (ultima) estado_prox = ENTREGA;
                end else if (cnt_gap == GW'(TIMEOUT - 1)) begin
                    estado_prox = OCIOSO;
                end
            end
            ENTREGA: begin
                if (cnt_hold == HW'(HOLD_CICLOS - 1)) estado_prox = OCIOSO;
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    // NOTE: the window register is an ordinary flop bank, not a RAM, so it is
    // cleared by reset like the rest of the state; state uses non-blocking only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mpu          <= '0;
            ldr_out      <= '0;
            mov          <= 1'b0;
            anterior     <= '0;
            tem_anterior <= 1'b0;
            cnt_amostra  <= '0;
            cnt_gap      <= '0;
            cnt_hold     <= '0;
        end else begin
            mov <= (estado_prox == ENTREGA);
            unique case (estado)
                OCIOSO: begin
                    cnt_gap  <= '0;
                    cnt_hold <= '0;
                    if (aceita) begin
                        anterior     <= amostra;
                        tem_anterior <= 1'b1;
                        if (estado_prox == CAPTURA) begin
                            mpu[LARGURA-1:0] <= amostra;
                            cnt_amostra      <= CW'(1);
                        end
                    end
                end
                CAPTURA: begin
                    if (aceita) begin
                        // Tracking the last sample keeps anterior valid on return to idle.
                        anterior    <= amostra;
                        cnt_gap     <= '0;
                        cnt_amostra <= cnt_amostra + 1'b1;
                        for (int k = 0; k < N_AMOSTRAS; k++) begin
                            if (cnt_amostra == CW'(k)) mpu[k*LARGURA +: LARGURA] <= amostra;
                        end
                        if (ultima) ldr_out <= ldr;
                    end else if (estado_prox == OCIOSO) begin
                        cnt_gap      <= '0;
                        cnt_amostra  <= '0;
                        tem_anterior <= 1'b0;
                    end else begin
                        cnt_gap <= cnt_gap + 1'b1;
                    end
                end
                ENTREGA: begin
                    if (estado_prox == OCIOSO) begin
                        cnt_hold    <= '0;
                        cnt_amostra <= '0;
                    end else begin
                        cnt_hold <= cnt_hold + 1'b1;
                    end
                end
                default: begin
                    cnt_amostra <= '0;
                    cnt_gap     <= '0;
                    cnt_hold    <= '0;
                end
            endcase
        end
    end

endmodule
